// File: rtl/dram_bus_frontend.sv
// C64 multiplexed DRAM bus front end: synchronises the strobes, latches row/column bytes
// and classifies every bus cycle into clock-aligned events for the SRAM/MMU core.
module dram_bus_frontend #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 31,
    parameter int PHASE_W     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         maddress,
    input  logic               _ras,
    input  logic               _cas,
    input  logic               _we,
    output logic [15:0]        address,
    output logic               bus_active,
    output logic               cyc_start,
    output logic               cyc_write,
    output logic               cyc_late,
    output logic               cyc_done,
    output logic               cyc_refresh,
    output logic [PHASE_W-1:0] cyc_phase,
    output logic [7:0]         refresh_count,
    output logic               err_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        ACTIVE,
        CBR,
        PRECHARGE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] ras_sync, cas_sync, we_sync;
    logic [7:0]             md_dly [SYNC_STAGES];
    logic                   ras_s, cas_s, we_s;
    logic                   ras_d, cas_d, we_d;
    logic [7:0]             md_s;
    logic                   ras_fall, ras_rise, cas_fall, we_fall;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   tmo_hit;

    logic ev_row, ev_start, ev_late, ev_done, ev_refresh;

    // Strobe synchronisers plus an equal-depth maddress delay so md_s lines up with strobe edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments in every clocked block keep all flops sampling pre-edge values.
            ras_sync <= '1;
            cas_sync <= '1;
            we_sync  <= '1;
            ras_d    <= 1'b1;
            cas_d    <= 1'b1;
            we_d     <= 1'b1;
            // NOTE: the delay line is a handful of flops, not a RAM, so resetting it is cheap and keeps md_s defined.
            for (int i = 0; i < SYNC_STAGES; i++) md_dly[i] <= '0;
        end else begin
            ras_sync <= {ras_sync[SYNC_STAGES-2:0], _ras};
            cas_sync <= {cas_sync[SYNC_STAGES-2:0], _cas};
            we_sync  <= {we_sync[SYNC_STAGES-2:0], _we};
            ras_d    <= ras_s;
            cas_d    <= cas_s;
            we_d     <= we_s;
            md_dly[0] <= maddress;
            for (int i = 1; i < SYNC_STAGES; i++) md_dly[i] <= md_dly[i-1];
        end
    end

    assign ras_s    = ras_sync[SYNC_STAGES-1];
    assign cas_s    = cas_sync[SYNC_STAGES-1];
    assign we_s     = we_sync[SYNC_STAGES-1];
    assign md_s     = md_dly[SYNC_STAGES-1];
    assign ras_fall = ras_d & ~ras_s;
    assign ras_rise = ~ras_d & ras_s;
    assign cas_fall = cas_d & ~cas_s;
    assign we_fall  = we_d & ~we_s;

    assign tmo_hit    = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT));
    assign bus_active = (state == ACTIVE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE: begin
                if (ras_fall)                state_next = cas_s ? ROW : CBR;
                else if (cas_fall && ras_s)  state_next = CBR;
            end
            ROW: begin
                if (tmo_hit)        state_next = PRECHARGE;
                else if (cas_fall)  state_next = ACTIVE;
                else if (ras_rise)  state_next = IDLE;
            end
            ACTIVE: begin
                if (tmo_hit)             state_next = PRECHARGE;
                else if (ras_s || cas_s) state_next = (ras_s && cas_s) ? IDLE : PRECHARGE;
            end
            CBR: begin
                if (tmo_hit)             state_next = PRECHARGE;
                else if (ras_s && cas_s) state_next = IDLE;
            end
            PRECHARGE: begin
                if (tmo_hit || (ras_s && cas_s)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Event decode; a timeout suppresses every other event in that clock.
    always_comb begin
        ev_row     = (state == IDLE) && ras_fall && cas_s;
        ev_start   = (state == ROW) && !tmo_hit && cas_fall;
        ev_done    = (state == ACTIVE) && !tmo_hit && (ras_s || cas_s);
        ev_late    = (state == ACTIVE) && !tmo_hit && !ev_done && we_fall && !cyc_write;
        ev_refresh = ((state == ROW) && !tmo_hit && !cas_fall && ras_rise)
                   || ((state == IDLE) && ras_fall && !cas_s)
                   || ((state == CBR) && !tmo_hit && ras_fall);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || state_next == IDLE || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            address       <= '0;
            cyc_start     <= 1'b0;
            cyc_write     <= 1'b0;
            cyc_late      <= 1'b0;
            cyc_done      <= 1'b0;
            cyc_refresh   <= 1'b0;
            err_timeout   <= 1'b0;
            cyc_phase     <= '0;
            refresh_count <= '0;
        end else begin
            cyc_start   <= ev_start;
            cyc_late    <= ev_late;
            cyc_done    <= ev_done;
            cyc_refresh <= ev_refresh;
            err_timeout <= tmo_hit;

            if (ev_row) address[7:0] <= md_s;
            if (ev_refresh) refresh_count <= refresh_count + 8'd1;

            // cyc_write survives the cyc_done clock and clears the clock after.
            if (ev_start) begin
                address[15:8] <= md_s;
                cyc_write     <= ~we_s;
                cyc_phase     <= '0;
            end else if (state == ACTIVE) begin
                if (cyc_phase != {PHASE_W{1'b1}}) cyc_phase <= cyc_phase + 1'b1;
                if (tmo_hit)      cyc_write <= 1'b0;
                else if (ev_late) cyc_write <= 1'b1;
            end else begin
                cyc_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dram_bus_frontend.sv
// Directed bench for dram_bus_frontend: reads, early/late writes, refreshes,
// timeout abort, asynchronous reset and simultaneous strobe fall.
module tb_dram_bus_frontend;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  maddress;
    logic        _ras, _cas, _we;
    logic [15:0] address;
    logic        bus_active, cyc_start, cyc_write, cyc_late, cyc_done, cyc_refresh, err_timeout;
    logic [3:0]  cyc_phase;
    logic [7:0]  refresh_count;

    int vectors = 0;
    int miscompares = 0;

    int n_start = 0, n_done = 0, n_late = 0, n_ref = 0, n_tmo = 0;
    logic [15:0] addr_at_start = '0;
    logic        write_at_start = 1'b0, write_at_done = 1'b0;

    dram_bus_frontend dut (
        .clock(clock), .reset(reset), .maddress(maddress),
        ._ras(_ras), ._cas(_cas), ._we(_we),
        .address(address), .bus_active(bus_active), .cyc_start(cyc_start),
        .cyc_write(cyc_write), .cyc_late(cyc_late), .cyc_done(cyc_done),
        .cyc_refresh(cyc_refresh), .cyc_phase(cyc_phase),
        .refresh_count(refresh_count), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    // Pulse tally, sampled on the inactive clock edge.
    always @(negedge clock) begin
        if (cyc_start) begin
            n_start <= n_start + 1;
            addr_at_start <= address;
            write_at_start <= cyc_write;
        end
        if (cyc_done) begin
            n_done <= n_done + 1;
            write_at_done <= cyc_write;
        end
        if (cyc_late)    n_late <= n_late + 1;
        if (cyc_refresh) n_ref <= n_ref + 1;
        if (err_timeout) n_tmo <= n_tmo + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; maddress = 8'h00; _ras = 1'b1; _cas = 1'b1; _we = 1'b1;
        wait_clk(2);
        vectors++; if (address !== 16'h0000) begin miscompares++; $display("FAIL reset_address: got %h want 0000", address); end
        vectors++; if ({bus_active, cyc_write} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {bus_active, cyc_write}); end
        vectors++; if ({cyc_start, cyc_late, cyc_done, cyc_refresh, err_timeout} !== 5'b0) begin miscompares++; $display("FAIL reset_pulses: got %b want 00000", {cyc_start, cyc_late, cyc_done, cyc_refresh, err_timeout}); end
        vectors++; if ({cyc_phase, refresh_count} !== 12'h000) begin miscompares++; $display("FAIL reset_counters: got %h want 000", {cyc_phase, refresh_count}); end
        reset = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_read;
        int s_start = n_start, s_done = n_done, s_late = n_late;
        maddress = 8'h34; wait_clk(1);
        _ras = 1'b0; wait_clk(4);
        maddress = 8'h12; wait_clk(1);
        _cas = 1'b0; wait_clk(2);
        vectors++; if (cyc_start !== 1'b0) begin miscompares++; $display("FAIL read_latency_early: got %b want 0", cyc_start); end
        wait_clk(1);
        vectors++; if (cyc_start !== 1'b1) begin miscompares++; $display("FAIL read_latency_pulse: got %b want 1", cyc_start); end
        vectors++; if (address !== 16'h1234) begin miscompares++; $display("FAIL read_address: got %h want 1234", address); end
        vectors++; if (cyc_write !== 1'b0) begin miscompares++; $display("FAIL read_write_flag: got %b want 0", cyc_write); end
        wait_clk(3);
        vectors++; if (cyc_phase !== 4'd3) begin miscompares++; $display("FAIL read_phase: got %0d want 3", cyc_phase); end
        vectors++; if (bus_active !== 1'b1) begin miscompares++; $display("FAIL read_active: got %b want 1", bus_active); end
        _ras = 1'b1; _cas = 1'b1; wait_clk(6);
        vectors++; if (n_start - s_start !== 1) begin miscompares++; $display("FAIL read_start_count: got %0d want 1", n_start - s_start); end
        vectors++; if (n_done - s_done !== 1) begin miscompares++; $display("FAIL read_done_count: got %0d want 1", n_done - s_done); end
        vectors++; if (n_late - s_late !== 0) begin miscompares++; $display("FAIL read_late_count: got %0d want 0", n_late - s_late); end
        vectors++; if ({bus_active, address} !== {1'b0, 16'h1234}) begin miscompares++; $display("FAIL read_idle_hold: got %h want 01234", {bus_active, address}); end
    endtask

    task automatic test_early_write;
        int s_start = n_start, s_done = n_done, s_late = n_late;
        _we = 1'b0; maddress = 8'h56; wait_clk(1);
        _ras = 1'b0; wait_clk(4);
        maddress = 8'h78; wait_clk(1);
        _cas = 1'b0; wait_clk(6);
        vectors++; if ({bus_active, cyc_write} !== 2'b11) begin miscompares++; $display("FAIL early_active_write: got %b want 11", {bus_active, cyc_write}); end
        _ras = 1'b1; _cas = 1'b1; _we = 1'b1; wait_clk(6);
        vectors++; if (addr_at_start !== 16'h7856) begin miscompares++; $display("FAIL early_address: got %h want 7856", addr_at_start); end
        vectors++; if (write_at_start !== 1'b1) begin miscompares++; $display("FAIL early_write_at_start: got %b want 1", write_at_start); end
        vectors++; if (n_late - s_late !== 0) begin miscompares++; $display("FAIL early_no_late: got %0d want 0", n_late - s_late); end
        vectors++; if ({n_start - s_start, n_done - s_done} !== {32'd1, 32'd1}) begin miscompares++; $display("FAIL early_start_done: got %0d/%0d want 1/1", n_start - s_start, n_done - s_done); end
    endtask

    task automatic test_late_write;
        int s_start = n_start, s_late = n_late;
        _we = 1'b1; maddress = 8'hBC; wait_clk(1);
        _ras = 1'b0; wait_clk(4);
        maddress = 8'h9A; wait_clk(1);
        _cas = 1'b0; wait_clk(3);
        vectors++; if ({cyc_start, cyc_write} !== 2'b10) begin miscompares++; $display("FAIL late_start_read: got %b want 10", {cyc_start, cyc_write}); end
        wait_clk(3);
        _we = 1'b0; wait_clk(3);
        vectors++; if ({cyc_late, cyc_write} !== 2'b11) begin miscompares++; $display("FAIL late_pulse: got %b want 11", {cyc_late, cyc_write}); end
        wait_clk(3);
        vectors++; if ({cyc_late, cyc_write} !== 2'b01) begin miscompares++; $display("FAIL late_hold: got %b want 01", {cyc_late, cyc_write}); end
        _ras = 1'b1; _cas = 1'b1; wait_clk(3);
        vectors++; if ({cyc_done, cyc_write} !== 2'b11) begin miscompares++; $display("FAIL late_done_write: got %b want 11", {cyc_done, cyc_write}); end
        wait_clk(1);
        vectors++; if ({cyc_done, cyc_write} !== 2'b00) begin miscompares++; $display("FAIL late_write_clear: got %b want 00", {cyc_done, cyc_write}); end
        _we = 1'b1; wait_clk(4);
        vectors++; if ({n_start - s_start, n_late - s_late} !== {32'd1, 32'd1}) begin miscompares++; $display("FAIL late_counts: got %0d/%0d want 1/1", n_start - s_start, n_late - s_late); end
        vectors++; if (address !== 16'h9ABC) begin miscompares++; $display("FAIL late_address: got %h want 9ABC", address); end
    endtask

    task automatic test_refresh;
        int s_ref = n_ref, s_start = n_start, s_done = n_done;
        // RAS-only refresh re-drives the current row byte so the address is left as it was.
        maddress = 8'hBC; wait_clk(1);
        _ras = 1'b0; wait_clk(6);
        _ras = 1'b1; wait_clk(6);
        maddress = 8'hEE; wait_clk(1);
        _cas = 1'b0; wait_clk(2);
        _ras = 1'b0; wait_clk(6);
        _ras = 1'b1; _cas = 1'b1; wait_clk(6);
        vectors++; if (n_ref - s_ref !== 2) begin miscompares++; $display("FAIL refresh_pulses: got %0d want 2", n_ref - s_ref); end
        vectors++; if (refresh_count !== 8'd2) begin miscompares++; $display("FAIL refresh_count: got %0d want 2", refresh_count); end
        vectors++; if ({n_start - s_start, n_done - s_done} !== {32'd0, 32'd0}) begin miscompares++; $display("FAIL refresh_no_access: got %0d/%0d want 0/0", n_start - s_start, n_done - s_done); end
        vectors++; if (address !== 16'h9ABC) begin miscompares++; $display("FAIL refresh_address: got %h want 9ABC", address); end
    endtask

    task automatic test_timeout;
        int s_tmo = n_tmo, s_done = n_done;
        maddress = 8'h11; wait_clk(1);
        _ras = 1'b0; wait_clk(4);
        maddress = 8'h22; wait_clk(1);
        _cas = 1'b0; wait_clk(25);
        vectors++; if ({bus_active, cyc_phase} !== {1'b1, 4'hF}) begin miscompares++; $display("FAIL timeout_phase_sat: got %h want 1F", {bus_active, cyc_phase}); end
        vectors++; if (n_tmo - s_tmo !== 0) begin miscompares++; $display("FAIL timeout_too_early: got %0d want 0", n_tmo - s_tmo); end
        wait_clk(15);
        vectors++; if (n_tmo - s_tmo !== 1) begin miscompares++; $display("FAIL timeout_pulse: got %0d want 1", n_tmo - s_tmo); end
        vectors++; if (n_done - s_done !== 0) begin miscompares++; $display("FAIL timeout_no_done: got %0d want 0", n_done - s_done); end
        vectors++; if ({bus_active, cyc_write} !== 2'b00) begin miscompares++; $display("FAIL timeout_aborted: got %b want 00", {bus_active, cyc_write}); end
        _ras = 1'b1; _cas = 1'b1; wait_clk(6);
        vectors++; if ({n_tmo - s_tmo, n_done - s_done} !== {32'd1, 32'd0}) begin miscompares++; $display("FAIL timeout_release: got %0d/%0d want 1/0", n_tmo - s_tmo, n_done - s_done); end
    endtask

    task automatic test_simultaneous;
        int s_ref = n_ref, s_start = n_start;
        maddress = 8'h77; wait_clk(1);
        _ras = 1'b0; _cas = 1'b0; wait_clk(6);
        vectors++; if (n_ref - s_ref !== 1) begin miscompares++; $display("FAIL simul_refresh: got %0d want 1", n_ref - s_ref); end
        vectors++; if (n_start - s_start !== 0) begin miscompares++; $display("FAIL simul_no_start: got %0d want 0", n_start - s_start); end
        vectors++; if (refresh_count !== 8'd3) begin miscompares++; $display("FAIL simul_count: got %0d want 3", refresh_count); end
        _ras = 1'b1; _cas = 1'b1; wait_clk(6);
    endtask

    task automatic test_reset_mid_access;
        int s_start, s_done;
        _we = 1'b0; maddress = 8'h45; wait_clk(1);
        _ras = 1'b0; wait_clk(4);
        maddress = 8'h67; wait_clk(1);
        _cas = 1'b0; wait_clk(5);
        vectors++; if ({bus_active, cyc_write, address} !== {2'b11, 16'h6745}) begin miscompares++; $display("FAIL midrst_pre: got %h want 36745", {bus_active, cyc_write, address}); end
        #2 reset = 1'b1;
        #1;
        vectors++; if ({bus_active, cyc_write, address} !== 18'h0) begin miscompares++; $display("FAIL midrst_async: got %h want 00000", {bus_active, cyc_write, address}); end
        vectors++; if ({cyc_phase, refresh_count} !== 12'h000) begin miscompares++; $display("FAIL midrst_counters: got %h want 000", {cyc_phase, refresh_count}); end
        _ras = 1'b1; _cas = 1'b1; _we = 1'b1; wait_clk(2);
        reset = 1'b0; wait_clk(3);
        s_start = n_start; s_done = n_done;
        maddress = 8'h0F; wait_clk(1);
        _ras = 1'b0; wait_clk(4);
        maddress = 8'hF0; wait_clk(1);
        _cas = 1'b0; wait_clk(5);
        _ras = 1'b1; _cas = 1'b1; wait_clk(6);
        vectors++; if ({addr_at_start, write_at_start} !== {16'hF00F, 1'b0}) begin miscompares++; $display("FAIL midrst_next_read: got %h want 1E01E", {addr_at_start, write_at_start}); end
        vectors++; if ({n_start - s_start, n_done - s_done} !== {32'd1, 32'd1}) begin miscompares++; $display("FAIL midrst_next_counts: got %0d/%0d want 1/1", n_start - s_start, n_done - s_done); end
    endtask

    task automatic test_refresh_wrap;
        int s_ref;
        reset = 1'b1; wait_clk(2);
        reset = 1'b0; wait_clk(3);
        s_ref = n_ref;
        for (int i = 0; i < 255; i++) begin
            _ras = 1'b0; wait_clk(4);
            _ras = 1'b1; wait_clk(4);
        end
        vectors++; if (refresh_count !== 8'hFF) begin miscompares++; $display("FAIL wrap_preset: got %h want FF", refresh_count); end
        _ras = 1'b0; wait_clk(4);
        _ras = 1'b1; wait_clk(4);
        vectors++; if (refresh_count !== 8'h00) begin miscompares++; $display("FAIL wrap_rollover: got %h want 00", refresh_count); end
        vectors++; if (n_ref - s_ref !== 256) begin miscompares++; $display("FAIL wrap_pulses: got %0d want 256", n_ref - s_ref); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_early_write();
        test_late_write();
        test_refresh();
        test_timeout();
        test_simultaneous();
        test_reset_mid_access();
        test_refresh_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
